// File: rtl/cnt_chk_pkg.sv
// Shared constants for the counter-stream checker: state codes and parameter defaults.
// No logic; no flow control.
package cnt_chk_pkg;

  localparam int DEF_WIDTH    = 4;
  localparam int DEF_LOCK_CNT = 4;
  localparam int DEF_STAT_W   = 8;

  localparam int ST_W = 2;

  localparam logic [ST_W-1:0] ST_SEARCH = 2'd0;
  localparam logic [ST_W-1:0] ST_VERIFY = 2'd1;
  localparam logic [ST_W-1:0] ST_LOCKED = 2'd2;

  typedef enum logic [ST_W-1:0] {
    S_SEARCH = ST_SEARCH,
    S_VERIFY = ST_VERIFY,
    S_LOCKED = ST_LOCKED,
    S_BAD    = 2'd3
  } state_t;

endpackage

// File: rtl/cnt_seq_checker_if.sv
// Sample stream into the checker and its status/statistics back out.
// Sample path is valid-only (no ready): the checker accepts every valid sample.
interface cnt_seq_checker_if
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAT_W = DEF_STAT_W
);

  logic              pi_vld;
  logic [WIDTH-1:0]  pi_cnt;
  logic              po_locked;
  logic              po_err;
  logic [STAT_W-1:0] po_err_cnt;
  logic [STAT_W-1:0] po_wrap_cnt;
  logic [ST_W-1:0]   po_state;

  modport master (
    output pi_vld, pi_cnt,
    input  po_locked, po_err, po_err_cnt, po_wrap_cnt, po_state
  );

  modport slave (
    input  pi_vld, pi_cnt,
    output po_locked, po_err, po_err_cnt, po_wrap_cnt, po_state
  );

endinterface

// File: rtl/sat_counter.sv
// Statistics counter that holds at all-ones; registered, updates on the edge after inc.
// No backpressure; inc is honoured every cycle until saturation.
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (inc && (cnt != {W{1'b1}})) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/cnt_seq_checker.sv
// Locks onto a +1 wrap-around count stream and flags breaks once locked; outputs registered, 1-cycle latency.
// No backpressure: every valid sample is consumed; invalid cycles freeze all state.
module cnt_seq_checker
  import cnt_chk_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int LOCK_CNT = DEF_LOCK_CNT,
  parameter int STAT_W   = DEF_STAT_W
) (
  input logic              clk,
  input logic              rst,
  cnt_seq_checker_if.slave bus
);

  localparam int RUN_W = 4;
  localparam logic [RUN_W-1:0] LOCK_V = RUN_W'(LOCK_CNT);

  state_t           state_q, state_nxt;
  logic [WIDTH-1:0] ref_q, ref_nxt;
  logic [RUN_W-1:0] run_q, run_nxt;
  logic             err_q, err_nxt;
  logic             err_inc;
  logic             wrap_inc;
  logic             good;
  logic             at_max;

  assign good   = (bus.pi_cnt == ref_q + WIDTH'(1));
  assign at_max = (ref_q == {WIDTH{1'b1}});

  always_comb begin
    state_nxt = state_q;
    ref_nxt   = ref_q;
    run_nxt   = run_q;
    err_nxt   = 1'b0;
    err_inc   = 1'b0;
    wrap_inc  = 1'b0;

    case (state_q)
      S_SEARCH: begin
        if (bus.pi_vld) begin
          ref_nxt   = bus.pi_cnt;
          run_nxt   = '0;
          state_nxt = S_VERIFY;
        end
      end
      S_VERIFY: begin
        if (bus.pi_vld) begin
          ref_nxt = bus.pi_cnt;
          if (good) begin
            run_nxt = run_q + RUN_W'(1);
            if (run_q + RUN_W'(1) == LOCK_V) begin
              state_nxt = S_LOCKED;
            end
          end else begin
            run_nxt = '0;
          end
        end
      end
      S_LOCKED: begin
        if (bus.pi_vld) begin
          ref_nxt = bus.pi_cnt;
          if (good) begin
            // good && at_max means max -> 0, the only legal wrap
            wrap_inc = at_max;
          end else begin
            err_nxt   = 1'b1;
            err_inc   = 1'b1;
            run_nxt   = '0;
            state_nxt = S_VERIFY;
          end
        end
      end
      default: begin
        state_nxt = S_SEARCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SEARCH;
      ref_q   <= '0;
      run_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_nxt;
      ref_q   <= ref_nxt;
      run_q   <= run_nxt;
      err_q   <= err_nxt;
    end
  end

  sat_counter #(.W(STAT_W)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (err_inc),
    .cnt (bus.po_err_cnt)
  );

  sat_counter #(.W(STAT_W)) u_wrap_cnt (
    .clk (clk),
    .rst (rst),
    .inc (wrap_inc),
    .cnt (bus.po_wrap_cnt)
  );

  assign bus.po_locked = (state_q == S_LOCKED);
  assign bus.po_err    = err_q;
  assign bus.po_state  = state_q;

endmodule

// File: doc/cnt_seq_checker.md
# cnt_seq_checker

Receive-side monitor for the 4-bit wrap-around counter stream produced by the free-running counter block.
- Samples an incoming count value, checks that each valid sample equals the previous one plus 1 modulo 2^WIDTH, and locks onto the sequence after a run of good transitions.
- Once locked, reports every break as an error pulse and counts errors and wraps.
- Sits directly downstream of the counter as its self-check and bring-up aid.

## Interface
Parameters:
- WIDTH, 4, bit width of the monitored count.
- LOCK_CNT, 4, consecutive good transitions required to enter LOCKED (range 1..15).
- STAT_W, 8, width of the error and wrap statistics counters.

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  reset, synchronous, active-high.
- pi_vld  input  1  pi_cnt is valid this cycle.
- pi_cnt  input  WIDTH  monitored count value.
- po_locked  output  1  high while in LOCKED.
- po_err  output  1  one-cycle pulse on a sequence break detected in LOCKED.
- po_err_cnt  output  STAT_W  saturating count of po_err pulses.
- po_wrap_cnt  output  STAT_W  saturating count of max→0 transitions seen while LOCKED.
- po_state  output  2  current state encoding, for debug.

## Operation
States:
- SEARCH=0: first valid sample is stored as the reference, run counter cleared, go to VERIFY.
- VERIFY=1, on each valid sample:
  - if pi_cnt == ref+1 (mod 2^WIDTH): run++; if run reaches LOCK_CNT, go to LOCKED.
  - otherwise: run=0, stay in VERIFY. No error is reported.
  - ref <= pi_cnt in both cases.
- LOCKED=2, on each valid sample:
  - good transition: ref <= pi_cnt, stay in LOCKED.
  - ref == 2^WIDTH-1 and pi_cnt == 0: also a good transition; po_wrap_cnt++.
  - mismatch: po_err=1 for one cycle, po_err_cnt++, ref <= pi_cnt, run=0, go to VERIFY.
- Encoding 3 is unused. If ever reached, return to SEARCH.

Common rules:
- pi_vld=0: no state, ref, run or statistic change. Gaps do not break the sequence.
- Repeated value (pi_cnt == ref) is a mismatch.
- Both statistics counters saturate at 2^STAT_W-1 and never wrap.
- An upstream counter reset mid-run (jump to 0 from anything other than max) is a mismatch and raises po_err if the checker is LOCKED.
- rst has priority over everything, including a coincident valid sample.
- Reset values: state=SEARCH, ref=0, run=0, po_locked=0, po_err=0, po_err_cnt=0, po_wrap_cnt=0, po_state=0.

## Timing
- All outputs are registered, with 1-cycle latency. A sample accepted at edge N updates po_locked, po_err, po_err_cnt, po_wrap_cnt and po_state at edge N, so they are visible during cycle N+1.
- With continuous valid samples, po_locked rises after valid sample number LOCK_CNT+1 (SEARCH sample plus LOCK_CNT good transitions).
- po_err is never high for more than one cycle per mismatching sample. Back-to-back mismatches in LOCKED yield exactly one pulse, because the FSM has already left LOCKED.
- po_err_cnt increments on the same edge that raises po_err.
- po_locked falls on the same edge that raises po_err.
- rst asserted for one cycle returns the block to the reset state on that edge. The first valid sample after rst is deasserted is taken in SEARCH.

## Structure
- Package cnt_chk_pkg holds:
  - state localparams ST_SEARCH, ST_VERIFY, ST_LOCKED;
  - default values for WIDTH, LOCK_CNT and STAT_W;
  - the 2-bit state width.
- Sub-module sat_counter (parameter W; ports clk, rst, inc, cnt) is instantiated twice, once for the error statistic and once for the wrap statistic.
- The top level holds the FSM, the ref register, the run counter, the comparator and the po_err register.

## Test plan
- Free-running source 0,1,…,15,0,… with pi_vld=1 from reset release → po_locked=1 from cycle 6 onward, po_err never asserts, po_wrap_cnt=1 one cycle after the first 15→0 sample.
- While locked, inject 7 in place of 5 (…3,4,7,8…) → one po_err pulse after the 7, po_err_cnt=1, po_locked low, relock after 8,9,10,11 (po_locked high one cycle after the 11).
- Random pi_vld=0 gaps in a correct sequence → no errors, and lock timing counts only valid samples.
- Upstream counter reset 0 while locked at value 9 → po_err=1, po_err_cnt=1, po_wrap_cnt unchanged.
- Repeated mismatches with STAT_W=2 → po_err_cnt saturates at 3.
- rst asserted while LOCKED, coincident with a mismatching valid sample → no po_err, all outputs 0, po_state=0.
